// File: rtl/clksel_sched.sv
// CPU clock-select scheduler: decides LS/HS clock moves per bus cycle,
// with post-IO hold-off, clock-cell handshake and switch timeout.
module clksel_sched #(
  parameter int IO_DELAY_W = 3,
  parameter int TIMEOUT    = 31,
  parameter int CNT_W      = 16
) (
  input  logic                  i_hsclk,
  input  logic                  i_rst,
  input  logic                  i_cyc_valid,
  input  logic                  i_cyc_himem,
  input  logic                  i_cyc_sync,
  input  logic                  i_cyc_io,
  input  logic                  i_cyc_vram_wr,
  input  logic                  i_cyc_idle,
  input  logic                  i_cfg_hsclk_en,
  input  logic [IO_DELAY_W-1:0] i_cfg_io_delay,
  input  logic                  i_hs_selected,
  input  logic                  i_ls_selected,
  output logic                  o_sel_hs,
  output logic                  o_dummy_access,
  output logic                  o_busy,
  output logic                  o_err,
  output logic [CNT_W-1:0]      o_sw_count
);

  typedef enum logic [1:0] {
    S_LS    = 2'd0,
    S_TO_HS = 2'd1,
    S_HS    = 2'd2,
    S_TO_LS = 2'd3
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IO_DELAY_W-1:0] r_io_cnt;
  logic [7:0]            r_timer;
  logic                  r_sel_hs;
  logic                  r_err;
  logic [CNT_W-1:0]      r_sw_count;

  logic w_io_block;
  logic w_timeout;
  logic w_promote;
  logic w_demote;
  logic w_inc;
  logic w_set_err;
  logic w_busy;

  assign w_io_block = (r_io_cnt != '0);
  assign w_timeout  = (r_timer == TMO);
  assign w_busy     = (r_state == S_TO_HS) || (r_state == S_TO_LS);

  assign w_promote = i_cyc_valid & i_cfg_hsclk_en & i_cyc_sync
                   & i_cyc_himem & ~w_io_block & ~i_cyc_io;

  assign w_demote = i_cyc_valid
                  & (~i_cfg_hsclk_en
                     | (~i_cyc_idle & (~i_cyc_himem | i_cyc_vram_wr)));

  // Next-state decode; enable drop beats ack, ack beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_inc       = 1'b0;
    w_set_err   = 1'b0;
    unique case (r_state)
      S_LS: begin
        if (w_promote) w_state_nxt = S_TO_HS;
      end
      S_TO_HS: begin
        if (!i_cfg_hsclk_en) begin
          w_state_nxt = S_TO_LS;
        end else if (i_hs_selected) begin
          w_state_nxt = S_HS;
          w_inc       = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_TO_LS;
          w_set_err   = 1'b1;
        end
      end
      S_HS: begin
        if (w_demote) w_state_nxt = S_TO_LS;
      end
      S_TO_LS: begin
        if (i_ls_selected) begin
          w_state_nxt = S_LS;
        end else if (w_timeout) begin
          w_state_nxt = S_LS;
          w_set_err   = 1'b1;
        end
      end
      default: w_state_nxt = S_LS;
    endcase
  end

  // State, registered clock request, sticky error and switch count.
  always_ff @(posedge i_hsclk) begin
    if (i_rst) begin
      r_state    <= S_LS;
      r_sel_hs   <= 1'b0;
      r_err      <= 1'b0;
      r_sw_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel_hs <= (w_state_nxt == S_TO_HS) || (w_state_nxt == S_HS);
      if (w_set_err) r_err <= 1'b1;
      if (w_inc && (r_sw_count != '1))
        r_sw_count <= r_sw_count + CNT_W'(1);
    end
  end

  // Post-IO hold-off counter, advanced once per completed bus cycle.
  always_ff @(posedge i_hsclk) begin
    if (i_rst) begin
      r_io_cnt <= '0;
    end else if (i_cyc_valid) begin
      if (i_cyc_io)
        r_io_cnt <= i_cfg_io_delay;
      else if (w_io_block)
        r_io_cnt <= r_io_cnt - IO_DELAY_W'(1);
    end
  end

  // Handshake timer: zero on any state change, counts while switching.
  always_ff @(posedge i_hsclk) begin
    if (i_rst) begin
      r_timer <= '0;
    end else if (w_state_nxt != r_state) begin
      r_timer <= '0;
    end else if (w_busy) begin
      r_timer <= r_timer + 8'd1;
    end
  end

  assign o_sel_hs       = r_sel_hs;
  assign o_busy         = w_busy;
  assign o_dummy_access = (r_state != S_LS);
  assign o_err          = r_err;
  assign o_sw_count     = r_sw_count;

endmodule

// File: tb/tb_clksel_sched.sv
// Bench for clksel_sched: directed scenarios with literal expectations
// plus randomized traffic compared against a behavioural model.
module tb_clksel_sched;
  localparam int IW = 3;
  localparam int TO = 31;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, valid, him, sync, io, vram, idle, cfg_en;
  logic [IW-1:0] dly;
  logic hs_s, ls_s;
  logic sel, dum, busy, err;
  logic [CW-1:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_pct = 0;

  always #5 clk = ~clk;

  clksel_sched #(
    .IO_DELAY_W(IW),
    .TIMEOUT(TO),
    .CNT_W(CW)
  ) dut (
    .i_hsclk(clk),
    .i_rst(rst),
    .i_cyc_valid(valid),
    .i_cyc_himem(him),
    .i_cyc_sync(sync),
    .i_cyc_io(io),
    .i_cyc_vram_wr(vram),
    .i_cyc_idle(idle),
    .i_cfg_hsclk_en(cfg_en),
    .i_cfg_io_delay(dly),
    .i_hs_selected(hs_s),
    .i_ls_selected(ls_s),
    .o_sel_hs(sel),
    .o_dummy_access(dum),
    .o_busy(busy),
    .o_err(err),
    .o_sw_count(cnt)
  );

  task automatic check(input string nm, input logic [CW+3:0] act,
                       input logic [CW+3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got {sel,busy,dummy,err,cnt}=%h want %h",
               nm, $time, act, exp);
    end
  endtask

  // Model: requested clock (HS or LS) and whether a switch is pending.
  bit m_req, m_pend, m_err, chk_en;
  int m_cnt, m_wait, m_hold;

  always @(posedge clk) begin
    bit blk;
    if (rst) begin
      m_req = 0; m_pend = 0; m_err = 0;
      m_cnt = 0; m_wait = 0; m_hold = 0;
      chk_en = 1;
    end else begin
      blk = (m_hold > 0);
      if (valid) begin
        if (io) m_hold = int'(dly);
        else if (m_hold > 0) m_hold--;
      end
      if (m_pend && m_req) begin
        if (!cfg_en) begin
          m_req = 0; m_wait = 0;
        end else if (hs_s) begin
          m_pend = 0;
          if (m_cnt < CMAX) m_cnt++;
        end else if (m_wait == TO) begin
          m_req = 0; m_err = 1; m_wait = 0;
        end else m_wait++;
      end else if (m_pend) begin
        if (ls_s) m_pend = 0;
        else if (m_wait == TO) begin
          m_pend = 0; m_err = 1;
        end else m_wait++;
      end else if (valid) begin
        if (!m_req) begin
          if (cfg_en && sync && him && !blk && !io) begin
            m_req = 1; m_pend = 1; m_wait = 0;
          end
        end else if (!cfg_en || (!idle && (!him || vram))) begin
          m_req = 0; m_pend = 1; m_wait = 0;
        end
      end
    end
    #1;
    if (chk_en)
      check("model", {sel, busy, dum, err, cnt},
            {m_req, m_pend, m_req | m_pend, m_err, CW'(m_cnt)});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc(input logic h, s, i, v, d);
    valid = 1; him = h; sync = s; io = i; vram = v; idle = d;
    step();
    valid = 0; him = 0; sync = 0; io = 0; vram = 0; idle = 0;
  endtask

  task automatic expect_o(input string nm, input logic s, b, d, e,
                          input logic [CW-1:0] c);
    check(nm, {sel, busy, dum, err, cnt}, {s, b, d, e, c});
  endtask

  task automatic trip();
    cyc(1, 1, 0, 0, 0);
    hs_s = 1; step(); hs_s = 0;
    cyc(0, 0, 0, 0, 0);
    ls_s = 1; step(); ls_s = 0;
  endtask

  initial begin
    rst = 1; valid = 0; him = 0; sync = 0; io = 0; vram = 0; idle = 0;
    cfg_en = 0; dly = '0; hs_s = 0; ls_s = 0;
    repeat (2) step();
    rst = 0;
    expect_o("reset", 0, 0, 0, 0, 8'd0);

    cfg_en = 1;
    cyc(1, 1, 0, 0, 0);
    expect_o("to_hs", 1, 1, 1, 0, 8'd0);
    hs_s = 1; step(); hs_s = 0;
    expect_o("in_hs", 1, 0, 1, 0, 8'd1);
    cyc(1, 0, 0, 0, 1);
    expect_o("hs_idle_stay", 1, 0, 1, 0, 8'd1);
    cyc(0, 0, 0, 0, 0);
    expect_o("to_ls", 0, 1, 1, 0, 8'd1);
    ls_s = 1; step(); ls_s = 0;
    expect_o("in_ls", 0, 0, 0, 0, 8'd1);

    dly = 3'd3;
    cyc(0, 0, 1, 0, 0);
    expect_o("io_cyc", 0, 0, 0, 0, 8'd1);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 0, 0, 0);
      expect_o("io_hold", 0, 0, 0, 0, 8'd1);
    end
    cyc(1, 1, 0, 0, 0);
    expect_o("io_release", 1, 1, 1, 0, 8'd1);
    hs_s = 1; step(); hs_s = 0;
    cyc(1, 0, 0, 1, 0);
    expect_o("vram_wr_down", 0, 1, 1, 0, 8'd2);
    ls_s = 1; step(); ls_s = 0;

    cyc(1, 1, 0, 0, 0);
    repeat (TO) step();
    expect_o("tmo_wait", 1, 1, 1, 0, 8'd2);
    step();
    expect_o("tmo_hs", 0, 1, 1, 1, 8'd2);
    repeat (TO) step();
    expect_o("tmo_ls_wait", 0, 1, 1, 1, 8'd2);
    step();
    expect_o("tmo_ls", 0, 0, 0, 1, 8'd2);

    rst = 1; step(); rst = 0;
    expect_o("reset2", 0, 0, 0, 0, 8'd0);
    cyc(1, 1, 0, 0, 0);
    repeat (TO) step();
    hs_s = 1; step(); hs_s = 0;
    expect_o("ack_vs_tmo", 1, 0, 1, 0, 8'd1);
    cyc(0, 0, 0, 0, 0);
    ls_s = 1; step(); ls_s = 0;

    cyc(1, 1, 0, 0, 0);
    cfg_en = 0; hs_s = 1; step(); hs_s = 0;
    expect_o("drop_vs_ack", 0, 1, 1, 0, 8'd1);
    ls_s = 1; step(); ls_s = 0;
    cfg_en = 1;

    for (int k = 0; k < CMAX - 2; k++) trip();
    expect_o("cnt_pre_sat", 0, 0, 0, 0, 8'hFE);
    trip();
    expect_o("cnt_sat", 0, 0, 0, 0, 8'hFF);
    trip();
    expect_o("cnt_stay_sat", 0, 0, 0, 0, 8'hFF);

    cyc(1, 1, 0, 0, 0);
    rst = 1; step(); rst = 0;
    expect_o("rst_mid", 0, 0, 0, 0, 8'd0);

    for (int i = 0; i < 20000; i++) begin
      if (i % 250 == 0) begin
        case ($urandom_range(0, 2))
          0: ack_pct = 0;
          1: ack_pct = 4;
          default: ack_pct = 40;
        endcase
        dly = IW'($urandom);
      end
      rst    = ($urandom_range(0, 1999) == 0);
      cfg_en = ($urandom_range(0, 99) < 93);
      valid  = ($urandom_range(0, 2) == 0);
      him    = valid & ($urandom_range(0, 1) == 1);
      sync   = valid & ($urandom_range(0, 1) == 1);
      io     = valid & ($urandom_range(0, 7) == 0);
      vram   = valid & ($urandom_range(0, 5) == 0);
      idle   = valid & ($urandom_range(0, 3) == 0);
      hs_s   = ($urandom_range(0, 99) < ack_pct);
      ls_s   = ($urandom_range(0, 99) < ack_pct);
      step();
    end

    rst = 0; valid = 0; hs_s = 0; ls_s = 0;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
